// File: rtl/key_pkg.sv
// Shared types and 50 MHz default timing for the key conditioning path.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } key_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500_000;     // 10 ms
    localparam int DEF_REPEAT_DELAY    = 25_000_000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 5_000_000;   // 100 ms

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; reset value is a parameter.
module sync_2ff #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce_pulse.sv
// Key synchroniser + debouncer producing a one-cycle press pulse and a debounced level.
// Optional auto-repeat pulses while held: define KEY_AUTO_REPEAT_EN.
//
// state       | meaning
// IDLE        | key released, waiting for a pressed sample
// PRESS_CHK   | pressed level seen, counting stable cycles
// HELD        | press accepted, debounced level is 1
// RELEASE_CHK | released level seen, counting stable cycles
module key_debounce_pulse
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
`ifdef KEY_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input  logic clk,
    input  logic rstn,
    input  logic key_i,
    output logic key_pluse_o,
    output logic key_level_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_sync;
    logic             key_s;
    key_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pulse_nxt;
    logic             level_nxt;
    logic             rpt_fire;

    // Reset value is the released pin level so leaving reset never looks like a press.
    sync_2ff #(
        .RST_VAL (KEY_ACTIVE_LOW)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (key_i),
        .q    (key_sync)
    );

    assign key_s = KEY_ACTIVE_LOW ? ~key_sync : key_sync;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (key_s) state_nxt = PRESS_CHK;
            end
            PRESS_CHK: begin
                if (!key_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                cnt_nxt = '0;
                if (!key_s) state_nxt = RELEASE_CHK;
            end
            RELEASE_CHK: begin
                if (key_s) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef KEY_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_first;
    logic [RPT_W-1:0] rpt_target;

    assign rpt_target = rpt_first ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_PERIOD);
    assign rpt_fire   = (state == HELD) && (rpt_cnt == rpt_target);

    // Frozen through RELEASE_CHK, but a bounce back into HELD restarts from zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (state == HELD) begin
            if (rpt_fire) begin
                rpt_cnt   <= RPT_W'(1);
                rpt_first <= 1'b0;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end else if (state != RELEASE_CHK || state_nxt == HELD) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // First HELD cycle is the only one where the registered level is still low.
    assign pulse_nxt = ((state == HELD) && !key_level_o) || rpt_fire;
    assign level_nxt = (state == HELD) || (state == RELEASE_CHK);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_pluse_o <= 1'b0;
            key_level_o <= 1'b0;
        end else begin
            key_pluse_o <= pulse_nxt;
            key_level_o <= level_nxt;
        end
    end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Self-checking bench for key_debounce_pulse with DEBOUNCE_CYCLES = 4; build with KEY_AUTO_REPEAT_EN for the repeat scenario.
module tb_key_debounce_pulse;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic key_i = 1'b1;
    logic key_pluse_o;
    logic key_level_o;

    int checks = 0;
    int errors = 0;

    // reference model: debounced level flips once the synchronised key has
    // disagreed with it on D+1 consecutive edges; outputs lag by one register
    bit m_d0, m_d1, m_deb, m_deb_prev;
    int m_run;
    int edge_n = 0;
    int pulse_count = 0;
    int pulse_q[$];

    key_debounce_pulse #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (4),
        .KEY_ACTIVE_LOW  (1'b1)
`ifdef KEY_AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
`endif
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .key_i       (key_i),
        .key_pluse_o (key_pluse_o),
        .key_level_o (key_level_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_d0 = 0; m_d1 = 0; m_deb = 0; m_deb_prev = 0; m_run = 0;
    endtask

    task automatic tick();
        bit ks, exp_level, exp_pulse;
        @(posedge clk);
        edge_n++;
        if (!rstn) begin
            model_reset();
            exp_level = 0;
            exp_pulse = 0;
        end else begin
            exp_level = m_deb;
            exp_pulse = m_deb && !m_deb_prev;
            ks = m_d1;
            m_d1 = m_d0;
            m_d0 = (key_i == 1'b0);
            m_deb_prev = m_deb;
            if (ks != m_deb) m_run++;
            else m_run = 0;
            if (m_run == D + 1) begin
                m_deb = !m_deb;
                m_run = 0;
            end
        end
        #1;
        check("level", int'(key_level_o), int'(exp_level));
`ifndef KEY_AUTO_REPEAT_EN
        check("pulse", int'(key_pluse_o), int'(exp_pulse));
`endif
        if (key_pluse_o === 1'b1) begin
            pulse_count++;
            pulse_q.push_back(edge_n);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_pulses();
        pulse_count = 0;
        pulse_q.delete();
    endtask

    function automatic int first_pulse();
        return (pulse_q.size() > 0) ? pulse_q[0] : -1;
    endfunction

    initial begin
        int t;
        model_reset();

        // 1: reset with key pressed, release reset with key released
        key_i = 1'b0;
        rstn = 1'b0;
        ticks(3);
        key_i = 1'b1;
        #2 rstn = 1'b1;
        clear_pulses();
        ticks(50);
        check("idle_pulses", pulse_count, 0);
        check("idle_level", int'(key_level_o), 0);

        // 2: clean press
        key_i = 1'b0;
        t = edge_n + 1;
        clear_pulses();
        ticks(100);
        check("clean_first_pulse", first_pulse(), t + D + 3);
`ifndef KEY_AUTO_REPEAT_EN
        check("clean_pulse_count", pulse_count, 1);
`endif
        check("clean_level", int'(key_level_o), 1);
        key_i = 1'b1;
        ticks(20);
        check("clean_release_level", int'(key_level_o), 0);

        // 3: bouncing press then stable
        clear_pulses();
        key_i = 1'b0; tick();
        key_i = 1'b1; tick();
        key_i = 1'b0; tick();
        key_i = 1'b1; tick();
        check("bounce_no_pulse", pulse_count, 0);
        key_i = 1'b0;
        t = edge_n + 1;
        ticks(40);
        check("bounce_first_pulse", first_pulse(), t + D + 3);
`ifndef KEY_AUTO_REPEAT_EN
        check("bounce_pulse_count", pulse_count, 1);
`endif

        // 4: release glitch while held, then a full release
        clear_pulses();
        key_i = 1'b1; ticks(2);
        key_i = 1'b0; ticks(20);
        check("glitch_level", int'(key_level_o), 1);
`ifndef KEY_AUTO_REPEAT_EN
        check("glitch_no_pulse", pulse_count, 0);
`endif
        key_i = 1'b1;
        ticks(20);
        check("full_release_level", int'(key_level_o), 0);

        // 5: reset while PRESS_CHK counter is 2
        key_i = 1'b0;
        ticks(5);
        #2 rstn = 1'b0;
        #1;
        check("rst_async_level", int'(key_level_o), 0);
        check("rst_async_pulse", int'(key_pluse_o), 0);
        model_reset();
        ticks(2);
        #2 rstn = 1'b1;
        t = edge_n + 1;
        clear_pulses();
        ticks(30);
        check("rst_first_pulse", first_pulse(), t + D + 3);
        key_i = 1'b1;
        ticks(20);

        // random bouncing segments with occasional async resets
        for (int s = 0; s < 150; s++) begin
            key_i = 1'($urandom_range(0, 1));
            ticks($urandom_range(1, 12));
            if ($urandom_range(0, 39) == 0) begin
                #2 rstn = 1'b0;
                #1;
                check("rnd_rst_level", int'(key_level_o), 0);
                model_reset();
                ticks($urandom_range(1, 3));
                #2 rstn = 1'b1;
            end
        end
        key_i = 1'b1;
        ticks(20);

`ifdef KEY_AUTO_REPEAT_EN
        // 6: auto-repeat pulse schedule
        clear_pulses();
        key_i = 1'b0;
        t = edge_n + 1;
        ticks(D + 3);
        check("rpt_first_pulse", first_pulse(), t + D + 3);
        while (edge_n < t + D + 3 + 20) tick();
        key_i = 1'b1;
        check("rpt_pulse_count", pulse_count, 4);
        if (pulse_q.size() == 4) begin
            check("rpt_pulse_10", pulse_q[1] - pulse_q[0], 10);
            check("rpt_pulse_15", pulse_q[2] - pulse_q[0], 15);
            check("rpt_pulse_20", pulse_q[3] - pulse_q[0], 20);
        end
        ticks(60);
        check("rpt_after_release", pulse_count, 4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
